// File: rtl/iob_wishbone2iob_pipe_if.sv
// Bus bundle between a pipelined Wishbone master and the IOb side of the bridge.
// The slave modport is the bridge's view; master is the view of whatever drives it.
interface iob_wishbone2iob_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   wb_addr_i;
  logic [DATA_W/8-1:0] wb_select_i;
  logic                wb_we_i;
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic [DATA_W-1:0]   wb_data_i;
  logic                wb_stall_o;
  logic                wb_ack_o;
  logic                wb_error_o;
  logic [DATA_W-1:0]   wb_data_o;
  logic                valid_o;
  logic [ADDR_W-1:0]   address_o;
  logic [DATA_W-1:0]   wdata_o;
  logic [DATA_W/8-1:0] wstrb_o;
  logic [DATA_W-1:0]   rdata_i;
  logic                ready_i;

  modport slave (
    input  wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
    output wb_stall_o, wb_ack_o, wb_error_o, wb_data_o,
    output valid_o, address_o, wdata_o, wstrb_o,
    input  rdata_i, ready_i
  );

  modport master (
    output wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
    input  wb_stall_o, wb_ack_o, wb_error_o, wb_data_o,
    input  valid_o, address_o, wdata_o, wstrb_o,
    output rdata_i, ready_i
  );
endinterface

// File: rtl/iob_wishbone2iob_pipe.sv
// Pipelined Wishbone B4 slave to IOb master bridge: request FIFO, stall back-pressure,
// ready watchdog reporting wb_error_o, and abort of queued requests when wb_cyc_i drops.
module iob_wishbone2iob_pipe #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REQ_DEPTH = 4,
  parameter int ADDR_MODE = 0,
  parameter int TIMEOUT_W = 8
) (
  input logic                    clk_i,
  input logic                    arst_i,
  iob_wishbone2iob_pipe_if.slave bus
);
  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SHIFT = $clog2(SEL_W);
  localparam logic [CNT_W-1:0]     FULL   = CNT_W'(REQ_DEPTH);
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] mem_addr [REQ_DEPTH];
  logic [DATA_W-1:0] mem_data [REQ_DEPTH];
  logic [SEL_W-1:0]  mem_sel  [REQ_DEPTH];
  logic              mem_we   [REQ_DEPTH];

  logic [PTR_W-1:0]     head, tail, head_nxt, tail_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [TIMEOUT_W-1:0] wdog, wdog_nxt;
  logic                 ack_q, err_q, ack_nxt, err_nxt;
  logic [DATA_W-1:0]    rdata_q;
  logic                 active, stall, push, pop, timeout, cyc;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
    if (ADDR_MODE == 1) return a << SHIFT;
    return a;
  endfunction

  assign cyc     = bus.wb_cyc_i;
  assign active  = (state != IDLE);
  assign stall   = (count == FULL);
  assign push    = cyc & bus.wb_stb_i & ~stall;
  assign timeout = active & ~bus.ready_i & (wdog == WD_MAX);
  assign pop     = active & (bus.ready_i | timeout);

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    wdog_nxt  = '0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (push) tail_nxt = tail + 1'b1;
    if (pop)  head_nxt = head + 1'b1;
    // Master abandoned the cycle: keep only the in-flight head, it cannot be withdrawn.
    if (active && !cyc) begin
      tail_nxt  = head + 1'b1;
      count_nxt = pop ? '0 : CNT_W'(1);
    end
    if (active && !pop) wdog_nxt = wdog + 1'b1;
    if (state == ISSUE && cyc) begin
      ack_nxt = pop & bus.ready_i;
      err_nxt = timeout;
    end
    case (state)
      IDLE: if (push) state_nxt = ISSUE;
      default: begin
        if (count_nxt == '0)  state_nxt = IDLE;
        else if (!cyc)        state_nxt = DRAIN;
        else if (pop)         state_nxt = ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wdog    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
      wdog  <= wdog_nxt;
      ack_q <= ack_nxt;
      err_q <= err_nxt;
      if (ack_nxt && !mem_we[head]) rdata_q <= bus.rdata_i;
    end
  end

  // Request storage carries no reset; outputs are masked by valid instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr[tail] <= map_addr(bus.wb_addr_i);
      mem_data[tail] <= bus.wb_data_i;
      mem_sel[tail]  <= bus.wb_select_i;
      mem_we[tail]   <= bus.wb_we_i;
    end
  end

  assign bus.wb_stall_o = stall;
  assign bus.wb_ack_o   = ack_q & cyc;
  assign bus.wb_error_o = err_q & cyc;
  assign bus.wb_data_o  = rdata_q;
  assign bus.valid_o    = active;
  assign bus.address_o  = active ? mem_addr[head] : '0;
  assign bus.wdata_o    = active ? mem_data[head] : '0;
  assign bus.wstrb_o    = (active && mem_we[head]) ? mem_sel[head] : '0;
endmodule

// File: tb/tb_iob_wishbone2iob_pipe.sv
// Directed-vector bench for iob_wishbone2iob_pipe: per-cycle input/expected-output table
// plus hand-written async-reset and word-address sequences.
module tb_iob_wishbone2iob_pipe;
  localparam logic        H = 1'b1, L = 1'b0;
  localparam logic [31:0] Z = 32'h0;
  localparam logic [3:0]  F = 4'hF, N = 4'h0;
  localparam logic [31:0] R  = 32'h1234_5678, C = 32'hCAFE_0001;
  localparam logic [31:0] D0 = 32'hA0A0_0100, D1 = 32'hA0A0_0104;
  localparam logic [31:0] D2 = 32'hA0A0_0108, D3 = 32'hA0A0_010C;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  iob_wishbone2iob_pipe_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  iob_wishbone2iob_pipe_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  iob_wishbone2iob_pipe #(.ADDR_W(32), .DATA_W(32), .REQ_DEPTH(4), .ADDR_MODE(0), .TIMEOUT_W(4))
    dut0 (.clk_i(clk), .arst_i(arst), .bus(bus0));
  iob_wishbone2iob_pipe #(.ADDR_W(32), .DATA_W(32), .REQ_DEPTH(4), .ADDR_MODE(1), .TIMEOUT_W(4))
    dut1 (.clk_i(clk), .arst_i(arst), .bus(bus1));

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;
    logic        rdy;
    logic [31:0] rdat;
    logic        e_valid, e_stall, e_ack, e_err;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdat, e_rdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic cyc, stb, we, input logic [31:0] addr, wdat,
                              input logic [3:0] sel, input logic rdy, input logic [31:0] rdat,
                              input logic ev, es, ea, ee, input logic [31:0] eaddr,
                              input logic [3:0] ews, input logic [31:0] ewd, erd);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.we = we; v.addr = addr; v.wdat = wdat; v.sel = sel;
    v.rdy = rdy; v.rdat = rdat;
    v.e_valid = ev; v.e_stall = es; v.e_ack = ea; v.e_err = ee;
    v.e_addr = eaddr; v.e_wstrb = ews; v.e_wdat = ewd; v.e_rdata = erd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus0.wb_cyc_i    = v.cyc;
    bus0.wb_stb_i    = v.stb;
    bus0.wb_we_i     = v.we;
    bus0.wb_addr_i   = v.addr;
    bus0.wb_data_i   = v.wdat;
    bus0.wb_select_i = v.sel;
    bus0.ready_i     = v.rdy;
    bus0.rdata_i     = v.rdat;
  endtask

  task automatic check_out(input string name, input vec_t v);
    nvec++;
    if (bus0.valid_o !== v.e_valid || bus0.wb_stall_o !== v.e_stall ||
        bus0.wb_ack_o !== v.e_ack || bus0.wb_error_o !== v.e_err ||
        bus0.address_o !== v.e_addr || bus0.wstrb_o !== v.e_wstrb ||
        bus0.wdata_o !== v.e_wdat || bus0.wb_data_o !== v.e_rdata) begin
      nmis++;
      $display("FAIL %s: got valid=%b stall=%b ack=%b err=%b addr=%h wstrb=%h wdata=%h rdata=%h; want valid=%b stall=%b ack=%b err=%b addr=%h wstrb=%h wdata=%h rdata=%h",
               name, bus0.valid_o, bus0.wb_stall_o, bus0.wb_ack_o, bus0.wb_error_o,
               bus0.address_o, bus0.wstrb_o, bus0.wdata_o, bus0.wb_data_o,
               v.e_valid, v.e_stall, v.e_ack, v.e_err, v.e_addr, v.e_wstrb, v.e_wdat, v.e_rdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // single write, ready after 3 cycles
    vq.push_back(mk(H,H,H,32'h10,32'hDEADBEEF,F,L,Z, L,L,L,L,Z,N,Z,Z));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(H,L,H,32'h10,32'hDEADBEEF,F,L,Z, H,L,L,L,32'h10,F,32'hDEADBEEF,Z));
    vq.push_back(mk(H,L,H,32'h10,32'hDEADBEEF,F,H,Z, H,L,L,L,32'h10,F,32'hDEADBEEF,Z));
    vq.push_back(mk(H,L,L,Z,Z,N,L,Z, L,L,H,L,Z,N,Z,Z));
    vq.push_back(mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,Z));
    // single read
    vq.push_back(mk(H,H,L,32'h20,Z,F,L,Z, L,L,L,L,Z,N,Z,Z));
    vq.push_back(mk(H,L,L,Z,Z,N,H,R, H,L,L,L,32'h20,N,Z,Z));
    vq.push_back(mk(H,L,L,Z,Z,N,L,Z, L,L,H,L,Z,N,Z,R));
    vq.push_back(mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,R));
    // four back-to-back reads, ready held high
    vq.push_back(mk(H,H,L,32'h100,Z,F,H,Z,  L,L,L,L,Z,N,Z,R));
    vq.push_back(mk(H,H,L,32'h104,Z,F,H,D0, H,L,L,L,32'h100,N,Z,R));
    vq.push_back(mk(H,H,L,32'h108,Z,F,H,D1, H,L,H,L,32'h104,N,Z,D0));
    vq.push_back(mk(H,H,L,32'h10C,Z,F,H,D2, H,L,H,L,32'h108,N,Z,D1));
    vq.push_back(mk(H,L,L,Z,Z,N,H,D3,       H,L,H,L,32'h10C,N,Z,D2));
    vq.push_back(mk(H,L,L,Z,Z,N,H,Z,        L,L,H,L,Z,N,Z,D3));
    vq.push_back(mk(L,L,L,Z,Z,N,L,Z,        L,L,L,L,Z,N,Z,D3));
    // six writes against a 4-deep buffer with ready low, then released
    vq.push_back(mk(H,H,H,32'h200,32'h5000,F,L,Z, L,L,L,L,Z,N,Z,D3));
    vq.push_back(mk(H,H,H,32'h204,32'h5001,F,L,Z, H,L,L,L,32'h200,F,32'h5000,D3));
    vq.push_back(mk(H,H,H,32'h208,32'h5002,F,L,Z, H,L,L,L,32'h200,F,32'h5000,D3));
    vq.push_back(mk(H,H,H,32'h20C,32'h5003,F,L,Z, H,L,L,L,32'h200,F,32'h5000,D3));
    vq.push_back(mk(H,H,H,32'h210,32'h5004,F,L,Z, H,H,L,L,32'h200,F,32'h5000,D3));
    vq.push_back(mk(H,H,H,32'h210,32'h5004,F,H,Z, H,H,L,L,32'h200,F,32'h5000,D3));
    vq.push_back(mk(H,H,H,32'h210,32'h5004,F,H,Z, H,L,H,L,32'h204,F,32'h5001,D3));
    vq.push_back(mk(H,H,H,32'h214,32'h5005,F,H,Z, H,L,H,L,32'h208,F,32'h5002,D3));
    vq.push_back(mk(H,L,L,Z,Z,N,H,Z, H,L,H,L,32'h20C,F,32'h5003,D3));
    vq.push_back(mk(H,L,L,Z,Z,N,H,Z, H,L,H,L,32'h210,F,32'h5004,D3));
    vq.push_back(mk(H,L,L,Z,Z,N,H,Z, H,L,H,L,32'h214,F,32'h5005,D3));
    vq.push_back(mk(H,L,L,Z,Z,N,H,Z, L,L,H,L,Z,N,Z,D3));
    vq.push_back(mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,D3));
    // watchdog: 16th cycle of valid without ready times out, next head issues at once
    vq.push_back(mk(H,H,L,32'h300,Z,F,L,Z, L,L,L,L,Z,N,Z,D3));
    vq.push_back(mk(H,H,L,32'h304,Z,F,L,Z, H,L,L,L,32'h300,N,Z,D3));
    for (int i = 0; i < 15; i++)
      vq.push_back(mk(H,L,L,Z,Z,N,L,Z, H,L,L,L,32'h300,N,Z,D3));
    vq.push_back(mk(H,L,L,Z,Z,N,H,C, H,L,L,H,32'h304,N,Z,D3));
    vq.push_back(mk(H,L,L,Z,Z,N,L,Z, L,L,H,L,Z,N,Z,C));
    vq.push_back(mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,C));
    // cycle abort with two queued: head held until ready, second discarded, no ack
    vq.push_back(mk(H,H,H,32'h400,32'h11,F,L,Z, L,L,L,L,Z,N,Z,C));
    vq.push_back(mk(H,H,H,32'h404,32'h22,F,L,Z, H,L,L,L,32'h400,F,32'h11,C));
    vq.push_back(mk(L,L,L,Z,Z,N,L,Z, H,L,L,L,32'h400,F,32'h11,C));
    vq.push_back(mk(L,L,L,Z,Z,N,L,Z, H,L,L,L,32'h400,F,32'h11,C));
    vq.push_back(mk(L,L,L,Z,Z,N,H,32'hBAD0BAD0, H,L,L,L,32'h400,F,32'h11,C));
    vq.push_back(mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,C));
    vq.push_back(mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,C));
    vq.push_back(mk(H,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,C));

    drive(mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,Z));
    bus1.wb_cyc_i = 1'b0; bus1.wb_stb_i = 1'b0; bus1.wb_we_i = 1'b0;
    bus1.wb_addr_i = '0; bus1.wb_data_i = '0; bus1.wb_select_i = '0;
    bus1.ready_i = 1'b0; bus1.rdata_i = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset", mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,Z));
    @(posedge clk); #1;
    arst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vq[i]);
      @(posedge clk); #1;
    end

    // asynchronous reset while a request is outstanding
    drive(mk(H,H,L,32'h500,Z,F,L,Z, L,L,L,L,Z,N,Z,Z));
    @(posedge clk); #1;
    drive(mk(H,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,Z));
    #1;
    check_out("midop_busy", mk(L,L,L,Z,Z,N,L,Z, H,L,L,L,32'h500,N,Z,C));
    #1 arst = 1'b1;
    #1;
    check_out("midop_reset", mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,Z));
    @(posedge clk); #1;
    arst = 1'b0;
    drive(mk(H,L,L,Z,Z,N,H,Z, L,L,L,L,Z,N,Z,Z));
    @(negedge clk);
    check_out("post_reset", mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,Z));
    @(posedge clk); #1;
    drive(mk(L,L,L,Z,Z,N,L,Z, L,L,L,L,Z,N,Z,Z));

    // word addressing: 0x3 becomes byte address 0xC
    bus1.wb_cyc_i = 1'b1; bus1.wb_stb_i = 1'b1; bus1.wb_addr_i = 32'h3; bus1.wb_select_i = 4'hF;
    @(posedge clk); #1;
    bus1.wb_stb_i = 1'b0;
    @(negedge clk);
    nvec++;
    if (bus1.valid_o !== 1'b1 || bus1.address_o !== 32'hC || bus1.wstrb_o !== 4'h0) begin
      nmis++;
      $display("FAIL word_addr: got valid=%b addr=%h wstrb=%h; want valid=1 addr=0000000c wstrb=0",
               bus1.valid_o, bus1.address_o, bus1.wstrb_o);
    end
    bus1.ready_i = 1'b1; bus1.rdata_i = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus1.ready_i = 1'b0;
    @(negedge clk);
    nvec++;
    if (bus1.wb_ack_o !== 1'b1 || bus1.wb_data_o !== 32'h0BAD_F00D || bus1.valid_o !== 1'b0) begin
      nmis++;
      $display("FAIL word_addr_ack: got ack=%b data=%h valid=%b; want ack=1 data=0badf00d valid=0",
               bus1.wb_ack_o, bus1.wb_data_o, bus1.valid_o);
    end
    bus1.wb_cyc_i = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
